// File: rtl/jstk_poll_scheduler.sv
// Poll sequencer for two PmodJSTK SPI interfaces: one period timer, joystick 1 then a
// fixed gap then joystick 2, with latched responses and sticky timeout/overrun flags.
module jstk_poll_scheduler #(
  parameter int unsigned POLL_DIV = 10_000_000,
  parameter int unsigned GAP_CYC  = 1000,
  parameter int unsigned TIMEOUT  = 2_000_000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        en,
  input  logic        clr_flags,
  input  logic [1:0]  led1,
  input  logic [1:0]  led2,
  input  logic [1:0]  xfer_done,
  input  logic [39:0] dout1,
  input  logic [39:0] dout2,
  output logic [1:0]  snd_rec,
  output logic [7:0]  din1,
  output logic [7:0]  din2,
  output logic [39:0] jstk_data1,
  output logic [39:0] jstk_data2,
  output logic [1:0]  valid,
  output logic [1:0]  timeout_flag,
  output logic        overrun_flag,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] XFER1 = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] XFER2 = 2'd3;

  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(POLL_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_nxt;
  logic [1:0]       valid_nxt;
  logic [1:0]       to_set;
  logic             tick;
  logic             start;

  assign tick  = (per_cnt == PER_LAST);
  assign start = tick && en && (state == IDLE);

  // One wait counter serves both the transfer timeout and the gap; it restarts on every state change.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt + 1'b1;
    valid_nxt = '0;
    to_set    = '0;
    case (state)
      IDLE: begin
        wait_nxt = '0;
        if (start) state_nxt = XFER1;
      end
      XFER1: begin
        if (xfer_done[0]) begin
          valid_nxt[0] = 1'b1;
          state_nxt    = GAP;
          wait_nxt     = '0;
        end else if (wait_cnt == TO_LAST) begin
          to_set[0] = 1'b1;
          state_nxt = GAP;
          wait_nxt  = '0;
        end
      end
      GAP: begin
        if (wait_cnt == GAP_LAST) begin
          state_nxt = XFER2;
          wait_nxt  = '0;
        end
      end
      XFER2: begin
        if (xfer_done[1]) begin
          valid_nxt[1] = 1'b1;
          state_nxt    = IDLE;
          wait_nxt     = '0;
        end else if (wait_cnt == TO_LAST) begin
          to_set[1] = 1'b1;
          state_nxt = IDLE;
          wait_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      per_cnt      <= '0;
      wait_cnt     <= '0;
      state        <= IDLE;
      snd_rec      <= '0;
      busy         <= 1'b0;
      valid        <= '0;
      din1         <= 8'h80;
      din2         <= 8'h80;
      jstk_data1   <= '0;
      jstk_data2   <= '0;
      timeout_flag <= '0;
      overrun_flag <= 1'b0;
    end else begin
      per_cnt  <= tick ? '0 : per_cnt + 1'b1;
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      // Outputs are decoded from the next state so they line up with the state register.
      snd_rec  <= {state_nxt == XFER2, state_nxt == XFER1};
      busy     <= (state_nxt != IDLE);
      valid    <= valid_nxt;
      if (start) begin
        din1 <= {6'b100000, led1};
        din2 <= {6'b100000, led2};
      end
      if (valid_nxt[0]) jstk_data1 <= dout1;
      if (valid_nxt[1]) jstk_data2 <= dout2;
      timeout_flag <= (timeout_flag & ~{2{clr_flags}}) | to_set;
      overrun_flag <= (overrun_flag & ~clr_flags) | (tick && (state != IDLE));
    end
  end

endmodule

// File: tb/tb_jstk_poll_scheduler.sv
// Randomized bench for jstk_poll_scheduler against an interval-based poll schedule model,
// with directed nominal, timeout, done/timeout race, mid-transfer reset and overrun cases.
module tb_jstk_poll_scheduler;

  localparam int POLL_DIV = 100;
  localparam int GAP_CYC  = 4;
  localparam int TO       = 50;
  localparam int TO_OV    = 200;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        en = 1'b0;
  logic        clr_flags = 1'b0;
  logic [1:0]  led1 = '0;
  logic [1:0]  led2 = '0;
  logic [1:0]  xfer_done = '0;
  logic [39:0] dout1 = '0;
  logic [39:0] dout2 = '0;

  logic [1:0]  snd_rec, valid, timeout_flag;
  logic [7:0]  din1, din2;
  logic [39:0] jstk_data1, jstk_data2;
  logic        overrun_flag, busy;

  logic [1:0]  snd_rec_ov, valid_ov, timeout_flag_ov;
  logic [7:0]  din1_ov, din2_ov;
  logic [39:0] jstk_data1_ov, jstk_data2_ov;
  logic        overrun_flag_ov, busy_ov;

  always #5 clk = ~clk;

  jstk_poll_scheduler #(.POLL_DIV(POLL_DIV), .GAP_CYC(GAP_CYC), .TIMEOUT(TO), .CNT_W(24)) dut (
    .clk(clk), .RST(RST), .en(en), .clr_flags(clr_flags), .led1(led1), .led2(led2),
    .xfer_done(xfer_done), .dout1(dout1), .dout2(dout2), .snd_rec(snd_rec),
    .din1(din1), .din2(din2), .jstk_data1(jstk_data1), .jstk_data2(jstk_data2),
    .valid(valid), .timeout_flag(timeout_flag), .overrun_flag(overrun_flag), .busy(busy)
  );

  jstk_poll_scheduler #(.POLL_DIV(POLL_DIV), .GAP_CYC(GAP_CYC), .TIMEOUT(TO_OV), .CNT_W(24)) dut_ov (
    .clk(clk), .RST(RST), .en(en), .clr_flags(clr_flags), .led1(led1), .led2(led2),
    .xfer_done(xfer_done), .dout1(dout1), .dout2(dout2), .snd_rec(snd_rec_ov),
    .din1(din1_ov), .din2(din2_ov), .jstk_data1(jstk_data1_ov), .jstk_data2(jstk_data2_ov),
    .valid(valid_ov), .timeout_flag(timeout_flag_ov), .overrun_flag(overrun_flag_ov), .busy(busy_ov)
  );

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  // Schedule of the current poll, in absolute cycles since reset release: [start, end) windows.
  int x1s, x1e, x2s, x2e, dn1, dn2;
  bit ok1, ok2;
  logic [39:0] cap1, cap2, e_data1, e_data2;
  logic [7:0]  e_din1, e_din2, p_din1, p_din2;
  logic [1:0]  e_to;
  logic        e_ov;
  bit din_pend, clr_pend, ov_pend;
  int poll_n = 0;
  bit strays_on = 1'b1;
  bit phase_b = 1'b0;
  bit did_rst = 1'b0;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, k, got, exp);
    end
  endtask

  function automatic bit in_win(input int a, input int b);
    return (k >= a) && (k < b);
  endfunction

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return TO - 1;
    if (r == 1) return TO + 3;
    return int'($urandom_range(0, TO - 2));
  endfunction

  task automatic model_reset();
    x1s = -1; x1e = -1; x2s = -1; x2e = -1; dn1 = -1; dn2 = -1;
    ok1 = 1'b0; ok2 = 1'b0;
    cap1 = '0; cap2 = '0; e_data1 = '0; e_data2 = '0;
    e_din1 = 8'h80; e_din2 = 8'h80;
    e_to = '0; e_ov = 1'b0;
    din_pend = 1'b0; clr_pend = 1'b0; ov_pend = 1'b0;
  endtask

  task automatic plan_poll();
    int d1, d2;
    if (phase_b) begin
      d1 = 10; d2 = TO + 5;
    end else begin
      case (poll_n)
        0:       begin d1 = 10;     d2 = 3;            end
        1:       begin d1 = TO + 5; d2 = pick_delay(); end
        2:       begin d1 = TO - 1; d2 = pick_delay(); end
        default: begin d1 = pick_delay(); d2 = pick_delay(); end
      endcase
    end
    x1s = k + 1;
    if (d1 < TO) begin dn1 = x1s + d1; x1e = dn1 + 1; ok1 = 1'b1; end
    else begin dn1 = -1; x1e = x1s + TO; ok1 = 1'b0; end
    x2s = x1e + GAP_CYC;
    if (d2 < TO) begin dn2 = x2s + d2; x2e = dn2 + 1; ok2 = 1'b1; end
    else begin dn2 = -1; x2e = x2s + TO; ok2 = 1'b0; end
    p_din1 = {6'b100000, led1};
    p_din2 = {6'b100000, led2};
    din_pend = 1'b1;
    poll_n++;
  endtask

  task automatic check_cycle();
    logic [1:0] es, ev;
    es = {in_win(x2s, x2e), in_win(x1s, x1e)};
    ev = {ok2 && (k == x2e), ok1 && (k == x1e)};
    check_eq("snd_rec", snd_rec, es);
    check_eq("busy", busy, in_win(x1s, x2e));
    check_eq("valid", valid, ev);
    check_eq("jstk_data1", jstk_data1, e_data1);
    check_eq("jstk_data2", jstk_data2, e_data2);
    check_eq("din1", din1, e_din1);
    check_eq("din2", din2, e_din2);
    check_eq("timeout_flag", timeout_flag, e_to);
    check_eq("overrun_flag", overrun_flag, e_ov);
  endtask

  task automatic step();
    bit tick, busy_k;
    logic [1:0] d;
    check_cycle();
    led1 = 2'($urandom_range(0, 3));
    led2 = 2'($urandom_range(0, 3));
    if (poll_n == 0) led1 = 2'b01;
    dout1 = {$urandom, 8'($urandom)};
    dout2 = {$urandom, 8'($urandom)};
    if (poll_n == 1) dout1 = 40'h11_2233_4455;
    if (phase_b) begin
      en = 1'b1;
      clr_flags = (k == 210);
    end else begin
      en = !(k >= 1000 && k < 1250) && ($urandom_range(0, 15) != 0);
      clr_flags = ($urandom_range(0, 39) == 0);
    end
    tick = (k % POLL_DIV) == (POLL_DIV - 1);
    busy_k = in_win(x1s, x2e);
    if (tick && en && !busy_k) plan_poll();
    ov_pend = tick && busy_k;
    d[0] = (k == dn1) || (strays_on && $urandom_range(0, 7) == 0 && !in_win(x1s, x1e));
    d[1] = (k == dn2) || (strays_on && $urandom_range(0, 7) == 0 && !in_win(x2s, x2e));
    xfer_done = d;
    if (k == dn1) cap1 = dout1;
    if (k == dn2) cap2 = dout2;
    clr_pend = clr_flags;
    @(posedge clk);
    #1;
    k++;
    if (clr_pend) begin e_to = '0; e_ov = 1'b0; end
    if (ov_pend) e_ov = 1'b1;
    if (k == x1e) begin if (ok1) e_data1 = cap1; else e_to[0] = 1'b1; end
    if (k == x2e) begin if (ok2) e_data2 = cap2; else e_to[1] = 1'b1; end
    if (din_pend) begin e_din1 = p_din1; e_din2 = p_din2; din_pend = 1'b0; end
  endtask

  task automatic apply_reset();
    RST = 1'b0;
    xfer_done = '0;
    clr_flags = 1'b0;
    #1;
    check_eq("rst_snd_rec", snd_rec, 2'b00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_valid", valid, 2'b00);
    check_eq("rst_data1", jstk_data1, 40'h0);
    check_eq("rst_data2", jstk_data2, 40'h0);
    check_eq("rst_din1", din1, 8'h80);
    check_eq("rst_din2", din2, 8'h80);
    check_eq("rst_flags", {overrun_flag, timeout_flag}, 3'b000);
    @(posedge clk);
    #1;
    RST = 1'b1;
    model_reset();
    k = 0;
  endtask

  initial begin
    #2;
    @(posedge clk);
    #1;
    apply_reset();

    for (int i = 0; i < 3000; i++) begin
      if (!did_rst && k >= 1500 && in_win(x2s, x2e)) begin
        check_eq("pre_reset_snd_rec1", snd_rec[1], 1'b1);
        apply_reset();
        did_rst = 1'b1;
      end
      step();
    end
    check_eq("mid_reset_exercised", did_rst, 1'b1);

    phase_b = 1'b1;
    strays_on = 1'b0;
    apply_reset();
    for (int i = 0; i < 230; i++) begin
      if (k == 199) check_eq("ov_flag_before_tick", overrun_flag_ov, 1'b0);
      if (k == 200) begin
        check_eq("ov_flag_at_tick", overrun_flag_ov, 1'b1);
        check_eq("ov_no_restart", snd_rec_ov, 2'b10);
        check_eq("ov_busy", busy_ov, 1'b1);
        check_eq("ov_no_timeout", timeout_flag_ov, 2'b00);
      end
      if (k == 211) check_eq("ov_flag_cleared", overrun_flag_ov, 1'b0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/jstk_poll_scheduler.md
# jstk_poll_scheduler

Sequences polling of the two PmodJSTK SPI interfaces from a single period timer, replacing the free-running shared 5 Hz send/receive strobe. Each poll slot it runs joystick 1, waits a fixed gap, then runs joystick 2, using a level request / done-pulse handshake. It latches each 40-bit response into a stable register and reports timeouts and overruns. It sits between the PmodJSTK instances and the joystick parsing and game logic, all in the board-clock domain.

## Interface
- POLL_DIV, 10_000_000: clk cycles per poll slot (5 Hz at 50 MHz); must be ≥ 2.
- GAP_CYC, 1000: idle cycles between the end of transfer 1 and the start of transfer 2; must be ≥ 1.
- TIMEOUT, 2_000_000: maximum cycles a transfer may wait for done; must be ≥ 2.
- CNT_W, 24: width of the period, gap and timeout counters; must hold POLL_DIV-1.

Ports:
- clk  in  1  board clock.
- RST  in  1  asynchronous, active-low reset.
- en  in  1  allows new poll cycles to start.
- clr_flags  in  1  synchronous pulse; clears the sticky flags.
- led1, led2  in  2  LED bits for each joystick command byte.
- xfer_done  in  2  one-cycle done pulse per interface: bit0 for jstk1, bit1 for jstk2.
- dout1, dout2  in  40  raw PmodJSTK response words.
- snd_rec  out  2  transfer request per interface; level signal.
- din1, din2  out  8  command bytes, {6'b100000, ledN}.
- jstk_data1, jstk_data2  out  40  latched responses.
- valid  out  2  one-cycle pulse when the matching jstk_data updates.
- timeout_flag  out  2  sticky, one bit per interface.
- overrun_flag  out  1  sticky.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Period counter:
  - Free-running 0..POLL_DIV-1 and wraps to 0.
  - tick = (count == POLL_DIV-1).
  - Runs regardless of en or state.
- FSM states: IDLE, XFER1, GAP, XFER2.
  - IDLE: on tick with en=1, go to XFER1.
    - Register din1/din2 from led1/led2 at this edge; they stay constant until the next cycle starts.
    - Clear the wait counter.
  - XFER1:
    - snd_rec[0]=1.
    - xfer_done[0] → latch dout1 into jstk_data1, pulse valid[0], go to GAP.
    - If wait count reaches TIMEOUT-1 without done → set timeout_flag[0], leave jstk_data1 unchanged, go to GAP.
  - GAP: hold for GAP_CYC cycles with snd_rec=0, then go to XFER2 and clear the wait counter.
  - XFER2: same as XFER1 but uses bit 1, dout2 and jstk_data2, and exits to IDLE.
- Boundary rules:
  - done and timeout in the same cycle → done wins; latch occurs, no flag set.
  - xfer_done bit not matching the current XFER state → ignored, including in IDLE and GAP.
  - tick while state ≠ IDLE → set overrun_flag and drop the tick; the cycle in progress is unaffected.
  - en falling mid-cycle → the current cycle completes; only new starts are blocked.
  - clr_flags together with a flag-set event in the same cycle → set wins.
  - snd_rec[0] and snd_rec[1] are never high together.
- Reset (RST=0, asynchronous):
  - state IDLE; all counters 0.
  - snd_rec, valid, flags and busy = 0.
  - jstk_data1/2 = 0; din1/din2 = 8'h80.
  - Mid-transfer reset drops snd_rec immediately and discards the transfer.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Tick at cycle T with en=1 → at T+1: busy=1, snd_rec[0]=1.
- xfer_done[0] at cycle D → at D+1: jstk_data1=dout1 (sampled at D), valid[0]=1 for one cycle, snd_rec[0]=0.
- After D+1, GAP occupies GAP_CYC cycles → snd_rec[1] rises at D+1+GAP_CYC.
- Timeout: XFER entered at cycle E with no done → at E+TIMEOUT: flag set and snd_rec low.
- xfer_done[1] at cycle F → at F+1: jstk_data2 latched, valid[1] pulses, state IDLE, busy=0.
- Next start is no sooner than the next tick.

## Test plan
Bench parameters for all scenarios: POLL_DIV=100, GAP_CYC=4, TIMEOUT=50.
- Nominal cycle: reset, en=1, led1=2'b01, dout1=40'h11_2233_4455, done[0] 10 cycles after snd_rec[0] rises.
  - Required: jstk_data1 matches, valid[0] pulse, snd_rec[1] rises exactly 4 cycles after snd_rec[0] falls, din1=8'h81.
- Timeout: never pulse done[0].
  - Required: snd_rec[0] high exactly 50 cycles, timeout_flag=2'b01, jstk_data1 holds its previous value, XFER2 still runs.
- Overrun: withhold done[1] and set TIMEOUT beyond POLL_DIV (TIMEOUT=200).
  - Required: overrun_flag=1 at the second tick, no restart; clr_flags clears it afterwards.
- Simultaneous done/timeout: pulse done[0] on cycle 49 of the wait.
  - Required: data latched, timeout_flag stays 0.
- Mid-transfer reset: assert RST=0 while snd_rec[1]=1.
  - Required: snd_rec=0 and jstk_data=0 at once; after release, no activity until the next tick.
- Enable and stray done: en=0 across two ticks → no snd_rec activity; a stray done[1] during XFER1 is ignored.
